// File: rtl/clmul_issue_seq_pkg.sv
// Shared definitions for the CLMUL/MUL issue sequencer: op codes, FSM states,
// and op legality decode.
package clmul_pkg;

  localparam logic [2:0] OP_CLMUL  = 3'd0;
  localparam logic [2:0] OP_CLMULH = 3'd1;
  localparam logic [2:0] OP_CLMULR = 3'd2;
  localparam logic [2:0] OP_MUL    = 3'd4;
  localparam logic [2:0] OP_MULHU  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Carry-less ops are only legal when the CLMUL datapath is enabled.
  function automatic logic op_is_legal(input logic [2:0] op, input logic disable_clmul);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_CLMUL, OP_CLMULH, OP_CLMULR: legal = !disable_clmul;
      OP_MUL, OP_MULHU:               legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Integer multiply ops run the multiplier in mul mode, all others carry-less.
  function automatic logic op_is_mul(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/clmul_issue_seq_if.sv
// Request, response and multiplier-side signals of the issue sequencer.
// slave: the sequencer; master: the surrounding pipeline and multiplier.
interface clmul_issue_seq_if #(
  parameter int unsigned TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_rd;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  logic             mul_start;
  logic             mul_mode;
  logic [31:0]      mul_rs1;
  logic [31:0]      mul_rs2;
  logic [63:0]      mul_rd;
  logic             mul_busy;
  logic             mul_done;

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, req_tag,
    input  rsp_ready,
    input  mul_rd, mul_busy, mul_done,
    output req_ready,
    output rsp_valid, rsp_rd, rsp_tag, rsp_err,
    output mul_start, mul_mode, mul_rs1, mul_rs2
  );

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, req_tag,
    output rsp_ready,
    output mul_rd, mul_busy, mul_done,
    input  req_ready,
    input  rsp_valid, rsp_rd, rsp_tag, rsp_err,
    input  mul_start, mul_mode, mul_rs1, mul_rs2
  );
endinterface

// File: rtl/clmul_issue_seq_result_select.sv
// Picks the 32-bit architectural result out of the 64-bit product by op.
module clmul_result_select
  import clmul_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [63:0] prod,
  output logic [31:0] result
);

  // Low half for CLMUL/MUL, high half for CLMULH/MULHU, bits 62:31 for CLMULR.
  always_comb begin
    result = '0;
    case (op)
      OP_CLMUL, OP_MUL:    result = prod[31:0];
      OP_CLMULH, OP_MULHU: result = prod[63:32];
      OP_CLMULR:           result = prod[62:31];
      default:             result = '0;
    endcase
  end

endmodule

// File: rtl/clmul_issue_seq.sv
// Issue/writeback sequencer in front of the multi-cycle CLMUL/MUL unit:
// accepts a request, pulses start, waits for done, returns the result slice.
module clmul_issue_seq
  import clmul_pkg::*;
#(
  parameter int unsigned TAG_W         = 5,
  parameter bit          DISABLE_CLMUL = 1'b0
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 flush,
  clmul_issue_seq_if.slave     bus
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      rs1_q, rs1_d;
  logic [31:0]      rs2_q, rs2_d;
  logic             mode_q, mode_d;
  logic [31:0]      rsp_rd_q, rsp_rd_d;
  logic             rsp_err_q, rsp_err_d;

  logic             req_ready;
  logic             req_fire;
  logic             req_legal;
  logic [31:0]      slice;
  logic             unused_busy;

  // Busy is informational only; completion is tracked purely by done.
  assign unused_busy = bus.mul_busy;

  clmul_result_select u_select (
    .op     (op_q),
    .prod   (bus.mul_rd),
    .result (slice)
  );

  assign req_ready = !flush &&
                     ((state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.rsp_ready));
  assign req_fire  = bus.req_valid && req_ready;
  assign req_legal = op_is_legal(bus.req_op, DISABLE_CLMUL);

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rd    = rsp_rd_q;
  assign bus.rsp_tag   = tag_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mul_start = (state_q == ST_ISSUE);
  assign bus.mul_mode  = mode_q;
  assign bus.mul_rs1   = rs1_q;
  assign bus.mul_rs2   = rs2_q;

  // Next-state and datapath update. Flush is applied last so it overrides
  // every other transition; req_ready is already low in a flush cycle.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tag_d     = tag_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    mode_d    = mode_q;
    rsp_rd_d  = rsp_rd_q;
    rsp_err_d = rsp_err_q;

    case (state_q)
      ST_IDLE:  state_d = ST_IDLE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.mul_done) begin
          rsp_rd_d = slice;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase

    // Illegal ops leave the operand/mode registers alone so a killed op that
    // is still running in the multiplier keeps stable inputs.
    if (req_fire) begin
      op_d     = bus.req_op;
      tag_d    = bus.req_tag;
      rsp_rd_d = '0;
      if (req_legal) begin
        rs1_d     = bus.req_rs1;
        rs2_d     = bus.req_rs2;
        mode_d    = op_is_mul(bus.req_op);
        rsp_err_d = 1'b0;
        state_d   = ST_ISSUE;
      end else begin
        rsp_err_d = 1'b1;
        state_d   = ST_RESP;
      end
    end

    if (flush) state_d = ST_IDLE;
  end

  // State and datapath registers; reset drops any in-flight work.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      tag_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      mode_q    <= 1'b0;
      rsp_rd_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      mode_q    <= mode_d;
      rsp_rd_q  <= rsp_rd_d;
      rsp_err_q <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_clmul_issue_seq.sv
// Directed self-checking bench for clmul_issue_seq with a behavioural
// 4-cycle multiplier (done sampled on the 4th edge after the start edge).
module tb_clmul_issue_seq;
  import clmul_pkg::*;

  localparam int unsigned TAG_W = 5;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  logic flush  = 1'b0;
  logic flush2 = 1'b0;
  int   tests  = 0;
  int   fails  = 0;

  clmul_issue_seq_if #(.TAG_W(TAG_W)) bus ();
  clmul_issue_seq_if #(.TAG_W(TAG_W)) bus2 ();

  clmul_issue_seq #(.TAG_W(TAG_W), .DISABLE_CLMUL(1'b0)) dut (
    .clock(clock), .resetn(resetn), .flush(flush), .bus(bus));

  clmul_issue_seq #(.TAG_W(TAG_W), .DISABLE_CLMUL(1'b1)) dut2 (
    .clock(clock), .resetn(resetn), .flush(flush2), .bus(bus2));

  always #5 clock = ~clock;

  // Behavioural multiplier with its own (absent) reset.
  int unsigned mcnt  = 0;
  logic [63:0] mprod = '0;

  function automatic logic [63:0] clmul64(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) if (b[i]) r = r ^ (64'(a) << i);
    return r;
  endfunction

  always @(posedge clock) begin
    if (bus.mul_start) begin
      mcnt  <= 4;
      mprod <= bus.mul_mode ? 64'(bus.mul_rs1) * 64'(bus.mul_rs2)
                            : clmul64(bus.mul_rs1, bus.mul_rs2);
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
    end
  end

  assign bus.mul_done  = (mcnt == 1);
  assign bus.mul_busy  = (mcnt != 0);
  assign bus.mul_rd    = mprod;
  assign bus2.mul_done = 1'b0;
  assign bus2.mul_busy = 1'b0;
  assign bus2.mul_rd   = '0;

  // Present one request to dut, accept it, and follow it to rsp_valid.
  // lat = 1 means rsp_valid was visible right after the accept edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, output int lat, output int starts,
                        output int start_at, output logic mode, output logic [31:0] rd,
                        output logic [TAG_W-1:0] t, output logic err);
    lat = -1; starts = 0; start_at = -1; mode = 1'bx; rd = 'x; t = 'x; err = 1'bx;
    @(negedge clock);
    bus.req_op = op; bus.req_rs1 = a; bus.req_rs2 = b; bus.req_tag = tag;
    bus.req_valid = 1'b1;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) begin @(posedge clock); #1; end
      if (bus.mul_start === 1'b1) begin
        starts++;
        if (start_at < 0) begin start_at = i; mode = bus.mul_mode; end
      end
      if (bus.rsp_valid === 1'b1) begin
        lat = i; rd = bus.rsp_rd; t = bus.rsp_tag; err = bus.rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.mul_start !== 1'b0 ||
        bus.mul_mode !== 1'b0 || bus.rsp_rd !== 32'h0 || bus.rsp_tag !== '0 ||
        bus.mul_rs1 !== 32'h0 || bus.mul_rs2 !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b err=%b start=%b mode=%b rd=%h tag=%h rs1=%h rs2=%h, all required 0",
               bus.rsp_valid, bus.rsp_err, bus.mul_start, bus.mul_mode, bus.rsp_rd,
               bus.rsp_tag, bus.mul_rs1, bus.mul_rs2);
    end
    #10 resetn = 1'b1;
    @(negedge clock);
    tests++;
    if (bus.req_ready !== 1'b1) begin
      fails++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_clmul();
    int lat, starts, start_at; logic mode; logic [31:0] rd; logic [TAG_W-1:0] t; logic err;
    bus.rsp_ready = 1'b1;
    run_op(OP_CLMUL, 32'h3, 32'h3, 5'd7, lat, starts, start_at, mode, rd, t, err);
    tests++;
    if (start_at !== 1 || starts !== 1 || mode !== 1'b0) begin
      fails++; $display("FAIL clmul_start: at=%0d count=%0d mode=%b want at=1 count=1 mode=0",
                        start_at, starts, mode);
    end
    tests++;
    if (lat !== 6) begin fails++; $display("FAIL clmul_latency: got %0d want 6", lat); end
    tests++;
    if (rd !== 32'h00000005 || t !== 5'd7 || err !== 1'b0) begin
      fails++; $display("FAIL clmul_rsp: rd=%h tag=%0d err=%b want 00000005 7 0", rd, t, err);
    end
  endtask

  task automatic test_mul();
    int lat, starts, start_at; logic mode; logic [31:0] rd; logic [TAG_W-1:0] t; logic err;
    run_op(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, lat, starts, start_at, mode, rd, t, err);
    tests++;
    if (rd !== 32'h00000001 || mode !== 1'b1 || t !== 5'd1 || err !== 1'b0) begin
      fails++; $display("FAIL mul_lo: rd=%h mode=%b tag=%0d err=%b want 00000001 1 1 0", rd, mode, t, err);
    end
    run_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, lat, starts, start_at, mode, rd, t, err);
    tests++;
    if (rd !== 32'hFFFFFFFE || mode !== 1'b1 || t !== 5'd2) begin
      fails++; $display("FAIL mulhu: rd=%h mode=%b tag=%0d want fffffffe 1 2", rd, mode, t);
    end
  endtask

  task automatic test_clmul_hi();
    int lat, starts, start_at; logic mode; logic [31:0] rd; logic [TAG_W-1:0] t; logic err;
    run_op(OP_CLMULH, 32'h80000000, 32'h80000000, 5'd3, lat, starts, start_at, mode, rd, t, err);
    tests++;
    if (rd !== 32'h40000000 || mode !== 1'b0 || t !== 5'd3) begin
      fails++; $display("FAIL clmulh: rd=%h mode=%b tag=%0d want 40000000 0 3", rd, mode, t);
    end
    run_op(OP_CLMULR, 32'h80000000, 32'h80000000, 5'd4, lat, starts, start_at, mode, rd, t, err);
    tests++;
    if (rd !== 32'h80000000 || mode !== 1'b0 || t !== 5'd4) begin
      fails++; $display("FAIL clmulr: rd=%h mode=%b tag=%0d want 80000000 0 4", rd, mode, t);
    end
  endtask

  task automatic test_illegal();
    int lat, starts, start_at; logic mode; logic [31:0] rd; logic [TAG_W-1:0] t; logic err;
    int late_starts;
    run_op(3'd3, 32'h1234, 32'h5678, 5'd5, lat, starts, start_at, mode, rd, t, err);
    late_starts = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (bus.mul_start === 1'b1) late_starts++;
    end
    tests++;
    if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || t !== 5'd5) begin
      fails++; $display("FAIL illegal_rsp: lat=%0d err=%b rd=%h tag=%0d want 1 1 0 5", lat, err, rd, t);
    end
    tests++;
    if (starts + late_starts !== 0) begin
      fails++; $display("FAIL illegal_no_start: got %0d starts want 0", starts + late_starts);
    end
  endtask

  task automatic test_disable_clmul();
    @(negedge clock);
    bus2.rsp_ready = 1'b1;
    bus2.req_op = OP_CLMUL; bus2.req_rs1 = 32'h3; bus2.req_rs2 = 32'h3; bus2.req_tag = 5'd14;
    bus2.req_valid = 1'b1;
    #1;
    tests++;
    if (bus2.req_ready !== 1'b1) begin
      fails++; $display("FAIL dis_req_ready: got %b want 1", bus2.req_ready);
    end
    @(posedge clock); #1;
    bus2.req_valid = 1'b0;
    tests++;
    if (bus2.rsp_valid !== 1'b1 || bus2.rsp_err !== 1'b1 || bus2.rsp_rd !== 32'h0 ||
        bus2.rsp_tag !== 5'd14 || bus2.mul_start !== 1'b0) begin
      fails++; $display("FAIL dis_clmul_illegal: valid=%b err=%b rd=%h tag=%0d start=%b want 1 1 0 14 0",
                        bus2.rsp_valid, bus2.rsp_err, bus2.rsp_rd, bus2.rsp_tag, bus2.mul_start);
    end
    // MUL stays legal with CLMUL disabled; kill it with flush afterwards.
    @(negedge clock);
    bus2.req_op = OP_MUL; bus2.req_tag = 5'd15; bus2.req_valid = 1'b1;
    @(posedge clock); #1;
    bus2.req_valid = 1'b0;
    tests++;
    if (bus2.mul_start !== 1'b1 || bus2.mul_mode !== 1'b1 || bus2.rsp_valid !== 1'b0) begin
      fails++; $display("FAIL dis_mul_legal: start=%b mode=%b valid=%b want 1 1 0",
                        bus2.mul_start, bus2.mul_mode, bus2.rsp_valid);
    end
    @(negedge clock); flush2 = 1'b1;
    @(negedge clock); flush2 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat, starts, start_at; logic mode; logic [31:0] rd; logic [TAG_W-1:0] t; logic err;
    int got;
    bus.rsp_ready = 1'b0;
    run_op(OP_CLMUL, 32'h3, 32'h3, 5'd9, lat, starts, start_at, mode, rd, t, err);
    tests++;
    if (lat !== 6 || rd !== 32'h5 || t !== 5'd9) begin
      fails++; $display("FAIL bp_first_rsp: lat=%0d rd=%h tag=%0d want 6 00000005 9", lat, rd, t);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rd !== 32'h5 || bus.rsp_tag !== 5'd9 ||
          bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b0) begin
        fails++; $display("FAIL bp_hold[%0d]: valid=%b rd=%h tag=%0d err=%b req_ready=%b want 1 5 9 0 0",
                          k, bus.rsp_valid, bus.rsp_rd, bus.rsp_tag, bus.rsp_err, bus.req_ready);
      end
    end
    @(negedge clock);
    bus.rsp_ready = 1'b1;
    bus.req_op = OP_MUL; bus.req_rs1 = 32'hFFFFFFFF; bus.req_rs2 = 32'hFFFFFFFF;
    bus.req_tag = 5'd10; bus.req_valid = 1'b1;
    #1;
    tests++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b1) begin
      fails++; $display("FAIL b2b_both_ready: req_ready=%b rsp_valid=%b want 1 1", bus.req_ready, bus.rsp_valid);
    end
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    tests++;
    if (bus.mul_start !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.mul_mode !== 1'b1) begin
      fails++; $display("FAIL b2b_start: start=%b rsp_valid=%b mode=%b want 1 0 1",
                        bus.mul_start, bus.rsp_valid, bus.mul_mode);
    end
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (bus.rsp_valid === 1'b1) begin got = 1; break; end
    end
    tests++;
    if (got !== 1 || bus.rsp_rd !== 32'h1 || bus.rsp_tag !== 5'd10) begin
      fails++; $display("FAIL b2b_second_rsp: seen=%0d rd=%h tag=%0d want 1 00000001 10",
                        got, bus.rsp_rd, bus.rsp_tag);
    end
  endtask

  task automatic test_flush();
    int seen_valid, seen_done;
    @(negedge clock);
    bus.rsp_ready = 1'b1;
    bus.req_op = OP_CLMULH; bus.req_rs1 = 32'h80000000; bus.req_rs2 = 32'h80000000;
    bus.req_tag = 5'd11; bus.req_valid = 1'b1;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    flush = 1'b1;
    bus.req_op = OP_MUL; bus.req_tag = 5'd12; bus.req_valid = 1'b1;
    #1;
    tests++;
    if (bus.req_ready !== 1'b0) begin
      fails++; $display("FAIL flush_req_ready: got %b want 0", bus.req_ready);
    end
    @(posedge clock); #1;
    flush = 1'b0; bus.req_valid = 1'b0;
    tests++;
    if (bus.mul_start !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      fails++; $display("FAIL flush_no_accept: start=%b valid=%b want 0 0", bus.mul_start, bus.rsp_valid);
    end
    seen_valid = 0; seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (bus.rsp_valid === 1'b1) seen_valid++;
      if (bus.mul_done === 1'b1) seen_done++;
    end
    tests++;
    if (seen_valid !== 0 || seen_done !== 1) begin
      fails++; $display("FAIL flush_stale_done: rsp_valid cycles=%0d done pulses=%0d want 0 1",
                        seen_valid, seen_done);
    end
    tests++;
    if (bus.req_ready !== 1'b1) begin
      fails++; $display("FAIL flush_idle_ready: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_reset_mid_wait();
    int seen_valid;
    @(negedge clock);
    bus.req_op = OP_MUL; bus.req_rs1 = 32'h12345678; bus.req_rs2 = 32'h9;
    bus.req_tag = 5'd13; bus.req_valid = 1'b1;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    tests++;
    if (bus.mul_rs1 !== 32'h12345678 || bus.mul_rs2 !== 32'h9 || bus.mul_mode !== 1'b1 ||
        bus.rsp_tag !== 5'd13) begin
      fails++; $display("FAIL pre_reset_regs: rs1=%h rs2=%h mode=%b tag=%0d want 12345678 9 1 13",
                        bus.mul_rs1, bus.mul_rs2, bus.mul_mode, bus.rsp_tag);
    end
    #2 resetn = 1'b0;
    #1;
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.mul_start !== 1'b0 ||
        bus.mul_mode !== 1'b0 || bus.rsp_rd !== 32'h0 || bus.rsp_tag !== '0 ||
        bus.mul_rs1 !== 32'h0 || bus.mul_rs2 !== 32'h0) begin
      fails++; $display("FAIL async_reset: valid=%b err=%b start=%b mode=%b rd=%h tag=%h rs1=%h rs2=%h, all required 0",
                        bus.rsp_valid, bus.rsp_err, bus.mul_start, bus.mul_mode, bus.rsp_rd,
                        bus.rsp_tag, bus.mul_rs1, bus.mul_rs2);
    end
    @(negedge clock);
    resetn = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (bus.rsp_valid === 1'b1) seen_valid++;
    end
    tests++;
    if (seen_valid !== 0) begin
      fails++; $display("FAIL reset_stale_done: rsp_valid cycles=%0d want 0", seen_valid);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_rs1 = '0; bus.req_rs2 = '0;
    bus.req_tag = '0; bus.rsp_ready = 1'b0;
    bus2.req_valid = 1'b0; bus2.req_op = '0; bus2.req_rs1 = '0; bus2.req_rs2 = '0;
    bus2.req_tag = '0; bus2.rsp_ready = 1'b0;

    test_reset();
    test_clmul();
    test_mul();
    test_clmul_hi();
    test_illegal();
    test_disable_clmul();
    test_back_to_back();
    test_flush();
    test_reset_mid_wait();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
